// File: rtl/spi_mem_master.sv
// spi_mem_master: single-bit SPI memory-access initiator.
// One host request becomes one cs_n-framed serial transfer, LSB first:
//   opcode bit (1=write), 8 address bits, then 8 write-data bits for writes.
//   Reads wait for mem_ready and then capture 8 bits from sdi.
// Optional feature macro: SPI_MASTER_TIMEOUT_EN adds a TIMEOUT_CYCLES abort
// in the wait states; without it the master waits indefinitely.
module spi_mem_master
`ifdef SPI_MASTER_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
`endif
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_we,
    input  logic [7:0] i_req_addr,
    input  logic [7:0] i_req_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_err,
    output logic       o_cs_n,
    output logic       o_sdo,
    input  logic       i_sdi,
    input  logic       i_mem_ready,
    input  logic       i_mem_done
);

    typedef enum logic [2:0] {
        StIdle,
        StOpcode,
        StShiftOut,
        StWaitReady,
        StShiftIn,
        StWaitDone
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [15:0] r_shift;      // {wdata, addr}, shifted out from bit 0
    logic [4:0]  r_bit_cnt;
    logic [7:0]  r_rdata;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [7:0]  r_rsp_rdata;
    logic        r_cs_n;
    logic        r_sdo;
    logic [4:0]  w_out_bits;

`ifdef SPI_MASTER_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT_CYCLES - 1);

    logic [WaitW-1:0] r_wait_cnt;
    logic             r_rsp_err;
    logic             w_wait_expired;

    assign w_wait_expired = (r_wait_cnt == WaitLast);
    assign o_rsp_err      = r_rsp_err;

    // Wait-state cycle counter; held at zero outside the wait states so it starts clean on entry.
    always_ff @(posedge clk) begin
        if (!rst_n || !(r_state == StWaitReady || r_state == StWaitDone)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign o_rsp_err = 1'b0;
`endif

    // Writes send address and data, reads send only the address.
    assign w_out_bits = r_we ? 5'd16 : 5'd8;

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_cs_n      = r_cs_n;
    assign o_sdo       = r_sdo;

    // Transaction FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_we        <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_rdata     <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_cs_n      <= 1'b1;
            r_sdo       <= 1'b0;
`ifdef SPI_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
`ifdef SPI_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_shift     <= {i_req_wdata, i_req_addr};
                        r_bit_cnt   <= '0;
                        r_cs_n      <= 1'b0;
                        r_sdo       <= i_req_we;
                        r_req_ready <= 1'b0;
                        r_state     <= StOpcode;
                    end
                end
                // Opcode bit stays on sdo for a second cycle.
                StOpcode: begin
                    r_state <= StShiftOut;
                end
                StShiftOut: begin
                    if (r_bit_cnt == w_out_bits) begin
                        r_cs_n    <= 1'b1;
                        r_sdo     <= 1'b0;
                        r_bit_cnt <= '0;
                        r_state   <= r_we ? StWaitDone : StWaitReady;
                    end else begin
                        r_sdo     <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[15:1]};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                end
                StWaitReady: begin
                    if (i_mem_ready) begin
                        r_bit_cnt <= '0;
                        r_state   <= StShiftIn;
                    end
`ifdef SPI_MASTER_TIMEOUT_EN
                    else if (w_wait_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_cs_n      <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
`endif
                end
                // First captured bit ends up in rdata[0] after eight right shifts.
                StShiftIn: begin
                    r_rdata   <= {i_sdi, r_rdata[7:1]};
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                    if (r_bit_cnt == 5'd7) begin
                        r_state <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (i_mem_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? 8'h00 : r_rdata;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
`ifdef SPI_MASTER_TIMEOUT_EN
                    else if (w_wait_expired) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_cs_n      <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
`endif
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
